ub_read_sequencer: RTL and testbench
====================================

UB_READ_SEQUENCER -- requirements
Module: ub_read_sequencer

Interface
REQ-001 SHALL have parameter N, default `ARRAY_SIZE, systolic array dimension.
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, unified buffer address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the transfer length field.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 2*N, enabled cycles to wait after the last issue before done.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, global advance enable, the same signal fed to the skewers.
REQ-008 SHALL have port start, input, 1, command strobe.
REQ-009 SHALL have ports input_base and weight_base, input, ADDR_WIDTH each, stream start addresses.
REQ-010 SHALL have ports input_stride and weight_stride, input, ADDR_WIDTH each, per-issue address increments.
REQ-011 SHALL have port length, input, LEN_WIDTH, number of rows (K) per stream.
REQ-012 SHALL have ports input_addr and weight_addr, output, ADDR_WIDTH each, UB read addresses.
REQ-013 SHALL have ports input_first_in, input_last_in, weight_first_in and weight_last_in, output, 1 each, stream framing to the UB.
REQ-014 SHALL have port issue_valid, output, 1, high on cycles when the addresses are a real read.
REQ-015 SHALL have port busy, output, 1, high from command acceptance until done.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, STREAM, DRAIN and DONE.
REQ-018 SHALL, in IDLE, accept start=1 regardless of en, latch base, stride and length, and set busy=1 on the next cycle.
REQ-019 SHALL, on start with length==0, go directly to DONE with no issue.
REQ-020 SHALL otherwise enter STREAM, issuing its first row on the cycle after start.
REQ-021 SHALL, in STREAM, drive issue_valid=1 and addresses for row k of: base + k*stride, mod 2^ADDR_WIDTH (wrap, no error), with k advancing only on cycles with en=1.
REQ-022 SHALL, on en=0, hold all outputs unchanged, including first and last.
REQ-023 SHALL assert first_in on row 0 only and last_in on row length-1 only, both streams identically; with length==1 both SHALL be high on the same row.
REQ-024 SHALL, after the last row is accepted (en=1), move to DRAIN and drop issue_valid, first_in and last_in to 0.
REQ-025 SHALL, in DRAIN, count DRAIN_CYCLES enabled cycles and then move to DONE.
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-027 SHALL accept a start in that same DONE cycle, so back-to-back commands are possible.
REQ-028 SHALL ignore start while busy=1; the latched command SHALL remain unaffected.
REQ-029 SHALL drive addresses to 0 and first/last to 0 outside STREAM.
REQ-030 SHALL compute addresses with running accumulators (no multiplier); the row counter SHALL be LEN_WIDTH wide.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-STREAM, force IDLE immediately with all outputs 0 and all counters and latched fields cleared.
REQ-032 SHALL, after reset release, require a fresh start and retain no partial command.

Structure
REQ-033 SHALL place the seq_state_t enum (IDLE, STREAM, DRAIN, DONE) in the shared npu_pkg package.
REQ-034 SHALL place DRAIN_CYCLES derivation constants in npu_pkg.
REQ-035 SHALL need no sub-module, because the row counter, drain counter and two address accumulators are inline registers.

Verification
REQ-036 SHALL cover: N=4, base_i=0x10, base_w=0x40, strides 1, length=4, en=1 -> issue_valid on cycles 1-4; addresses 0x10-0x13 and 0x40-0x43; first on cycle 1, last on cycle 4; done on cycle 4+8+1.
REQ-037 SHALL cover: the same command with en=0 on cycles 2-3 -> row-1 outputs held for 3 cycles; done delayed by 2.
REQ-038 SHALL cover: length=1 -> a single issue with first=last=1; length=0 -> done on cycle 1, no issue_valid.
REQ-039 SHALL cover: base_i=2^ADDR_WIDTH-2, stride 1, length=4 -> addresses wrap to 0 and 1.
REQ-040 SHALL cover: start pulsed mid-STREAM -> ignored; a second start in the DONE cycle -> a new stream on the next cycle.
REQ-041 SHALL cover: rst_n low at row 2 -> all outputs 0 immediately; busy=0; no done.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: sequencer state encoding and drain-depth derivation.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package npu_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} seq_state_t;

  // The skewed array needs 2*N enabled cycles to flush the last row through.
  localparam int unsigned DRAIN_PER_N = 2;

  function automatic int unsigned drain_cycles(input int unsigned n);
    return DRAIN_PER_N * n;
  endfunction

endpackage

// File: rtl/ub_read_sequencer.sv
// Issues strided unified-buffer reads for the input and weight streams of one
// systolic-array command, then waits for the array to drain before pulsing done.
module ub_read_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned N            = `ARRAY_SIZE,
  parameter int unsigned ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned DRAIN_CYCLES = drain_cycles(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] input_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] input_stride,
  input  logic [ADDR_WIDTH-1:0] weight_stride,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  input_first_in,
  output logic                  input_last_in,
  output logic                  weight_first_in,
  output logic                  weight_last_in,
  output logic                  issue_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DcW-1:0] DrainLast = DcW'(DRAIN_CYCLES - 1);

  seq_state_t            r_state;
  logic [LEN_WIDTH-1:0]  r_row;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [DcW-1:0]        r_drain;
  // Accumulators hold the address of the next row, so no multiplier is needed.
  logic [ADDR_WIDTH-1:0] r_in_acc;
  logic [ADDR_WIDTH-1:0] r_wt_acc;
  logic [ADDR_WIDTH-1:0] r_in_stride;
  logic [ADDR_WIDTH-1:0] r_wt_stride;

  logic [LEN_WIDTH-1:0]  w_row_next;
  logic [LEN_WIDTH-1:0]  w_len_m1;
  logic                  w_last_row;

  assign w_row_next = r_row + LEN_WIDTH'(1);
  assign w_len_m1   = r_len - LEN_WIDTH'(1);
  assign w_last_row = (r_row == w_len_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_row           <= '0;
      r_len           <= '0;
      r_drain         <= '0;
      r_in_acc        <= '0;
      r_wt_acc        <= '0;
      r_in_stride     <= '0;
      r_wt_stride     <= '0;
      input_addr      <= '0;
      weight_addr     <= '0;
      input_first_in  <= 1'b0;
      input_last_in   <= 1'b0;
      weight_first_in <= 1'b0;
      weight_last_in  <= 1'b0;
      issue_valid     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          if (start) begin
            r_len       <= length;
            r_in_stride <= input_stride;
            r_wt_stride <= weight_stride;
            r_row       <= '0;
            r_drain     <= '0;
            if (length == '0) begin
              r_state <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state         <= STREAM;
              busy            <= 1'b1;
              issue_valid     <= 1'b1;
              input_addr      <= input_base;
              weight_addr     <= weight_base;
              r_in_acc        <= input_base + input_stride;
              r_wt_acc        <= weight_base + weight_stride;
              input_first_in  <= 1'b1;
              weight_first_in <= 1'b1;
              input_last_in   <= (length == LEN_WIDTH'(1));
              weight_last_in  <= (length == LEN_WIDTH'(1));
            end
          end
        end
        STREAM: begin
          if (en) begin
            if (w_last_row) begin
              r_state         <= DRAIN;
              issue_valid     <= 1'b0;
              input_addr      <= '0;
              weight_addr     <= '0;
              input_first_in  <= 1'b0;
              weight_first_in <= 1'b0;
              input_last_in   <= 1'b0;
              weight_last_in  <= 1'b0;
            end else begin
              r_row           <= w_row_next;
              input_addr      <= r_in_acc;
              weight_addr     <= r_wt_acc;
              r_in_acc        <= r_in_acc + r_in_stride;
              r_wt_acc        <= r_wt_acc + r_wt_stride;
              input_first_in  <= 1'b0;
              weight_first_in <= 1'b0;
              input_last_in   <= (w_row_next == w_len_m1);
              weight_last_in  <= (w_row_next == w_len_m1);
            end
          end
        end
        DRAIN: begin
          if (en) begin
            if (r_drain == DrainLast) begin
              r_state <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_drain <= r_drain + DcW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Randomized and directed checks of ub_read_sequencer against a row/phase-level model.
module tb_ub_read_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned DC = 2 * N;

  localparam int PhIdle = 0;
  localparam int PhStream = 1;
  localparam int PhDrain = 2;
  localparam int PhDone = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] input_base = '0;
  logic [AW-1:0] weight_base = '0;
  logic [AW-1:0] input_stride = '0;
  logic [AW-1:0] weight_stride = '0;
  logic [LW-1:0] length = '0;
  logic [AW-1:0] input_addr;
  logic [AW-1:0] weight_addr;
  logic          input_first_in;
  logic          input_last_in;
  logic          weight_first_in;
  logic          weight_last_in;
  logic          issue_valid;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  // Model: which phase, which row k, how many drain cycles seen, latched command.
  int          m_phase = PhIdle;
  int unsigned m_k = 0;
  int unsigned m_d = 0;
  int unsigned m_len = 0;
  int unsigned m_ib = 0;
  int unsigned m_wb = 0;
  int unsigned m_is = 0;
  int unsigned m_ws = 0;

  ub_read_sequencer #(
    .N          (N),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .start           (start),
    .input_base      (input_base),
    .weight_base     (weight_base),
    .input_stride    (input_stride),
    .weight_stride   (weight_stride),
    .length          (length),
    .input_addr      (input_addr),
    .weight_addr     (weight_addr),
    .input_first_in  (input_first_in),
    .input_last_in   (input_last_in),
    .weight_first_in (weight_first_in),
    .weight_last_in  (weight_last_in),
    .issue_valid     (issue_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] row_addr(input int unsigned b, input int unsigned s,
                                             input int unsigned k);
    int unsigned a;
    a = b + s * k;
    return a[AW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PhIdle;
    m_k = 0;
    m_d = 0;
    m_len = 0;
    m_ib = 0;
    m_wb = 0;
    m_is = 0;
    m_ws = 0;
  endtask

  task automatic check_zero();
    chk("rst_input_addr", 32'(input_addr), 0);
    chk("rst_weight_addr", 32'(weight_addr), 0);
    chk("rst_input_first", 32'(input_first_in), 0);
    chk("rst_input_last", 32'(input_last_in), 0);
    chk("rst_weight_first", 32'(weight_first_in), 0);
    chk("rst_weight_last", 32'(weight_last_in), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
  endtask

  // Reference model advance plus per-cycle comparison.
  always @(posedge clk) begin
    if (rst_n) begin
      case (m_phase)
        PhIdle, PhDone: begin
          m_phase = PhIdle;
          if (start) begin
            m_ib = 32'(input_base);
            m_wb = 32'(weight_base);
            m_is = 32'(input_stride);
            m_ws = 32'(weight_stride);
            m_len = 32'(length);
            m_k = 0;
            m_d = 0;
            m_phase = (m_len == 0) ? PhDone : PhStream;
          end
        end
        PhStream: if (en) begin
          if (m_k == m_len - 1) m_phase = PhDrain;
          else m_k++;
        end
        PhDrain: if (en) begin
          m_d++;
          if (m_d == DC) m_phase = PhDone;
        end
        default: m_phase = PhIdle;
      endcase
    end
    #1;
    begin
      logic v;
      v = (m_phase == PhStream);
      chk("issue_valid", 32'(issue_valid), 32'(v));
      chk("input_addr", 32'(input_addr), v ? 32'(row_addr(m_ib, m_is, m_k)) : 0);
      chk("weight_addr", 32'(weight_addr), v ? 32'(row_addr(m_wb, m_ws, m_k)) : 0);
      chk("input_first", 32'(input_first_in), 32'(v && m_k == 0));
      chk("weight_first", 32'(weight_first_in), 32'(v && m_k == 0));
      chk("input_last", 32'(input_last_in), 32'(v && m_k == m_len - 1));
      chk("weight_last", 32'(weight_last_in), 32'(v && m_k == m_len - 1));
      chk("busy", 32'(busy), 32'(m_phase == PhStream || m_phase == PhDrain));
      chk("done", 32'(done), 32'(m_phase == PhDone));
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    model_reset();
    #1;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Base command 0x10/0x40 stride 1 length 4; hold pauses en in cycles 2-3,
  // extras adds an ignored mid-stream start and a back-to-back start in DONE.
  task automatic dir_basic(input bit hold, input bit extras);
    @(negedge clk);
    en = 1'b1;
    input_base = 8'h10;
    weight_base = 8'h40;
    input_stride = 8'd1;
    weight_stride = 8'd1;
    length = 16'd4;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      int row;
      int done_c;
      int busy_end;
      @(posedge clk);
      #1;
      if (!hold) row = (c <= 4) ? c - 1 : -1;
      else row = (c == 1) ? 0 : (c <= 4) ? 1 : (c <= 6) ? c - 3 : -1;
      done_c = hold ? 15 : 13;
      busy_end = done_c - 1;
      if (row >= 0) begin
        chk("d_valid", 32'(issue_valid), 1);
        chk("d_iaddr", 32'(input_addr), 32'h10 + 32'(row));
        chk("d_waddr", 32'(weight_addr), 32'h40 + 32'(row));
        chk("d_first", 32'(input_first_in), 32'(row == 0));
        chk("d_last", 32'(weight_last_in), 32'(row == 3));
      end else if (extras && (c == 14 || c == 15)) begin
        chk("b2b_valid", 32'(issue_valid), 1);
        chk("b2b_iaddr", 32'(input_addr), 32'h80 + 32'(c - 14));
        chk("b2b_waddr", 32'(weight_addr), 32'hC0 + 32'(c - 14));
        chk("b2b_last", 32'(input_last_in), 32'(c == 15));
      end else begin
        chk("d_valid_off", 32'(issue_valid), 0);
        chk("d_iaddr_off", 32'(input_addr), 0);
      end
      chk("d_done", 32'(done), 32'(c == done_c));
      chk("d_busy", 32'(busy), 32'(c <= busy_end || (extras && c >= 14)));
      @(negedge clk);
      start = 1'b0;
      en = !(hold && (c == 2 || c == 3));
      if (extras && c == 2) begin
        start = 1'b1;
        input_base = 8'hAA;
        length = 16'd7;
      end
      if (extras && c == 13) begin
        start = 1'b1;
        input_base = 8'h80;
        weight_base = 8'hC0;
        length = 16'd2;
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic dir_short(input int unsigned len);
    @(negedge clk);
    en = 1'b1;
    input_base = 8'h05;
    weight_base = 8'h20;
    input_stride = 8'd3;
    weight_stride = 8'd3;
    length = LW'(len);
    start = 1'b1;
    for (int unsigned c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk("s_valid", 32'(issue_valid), 32'(c <= len));
      chk("s_first", 32'(input_first_in), 32'(len > 0 && c == 1));
      chk("s_last", 32'(weight_last_in), 32'(len > 0 && c == len));
      chk("s_done", 32'(done), 32'(c == ((len == 0) ? 1 : len + DC + 1)));
      chk("s_busy", 32'(busy), 32'(len > 0 && c <= len + DC));
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic dir_wrap();
    logic [7:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    @(negedge clk);
    en = 1'b1;
    input_base = 8'hFE;
    weight_base = 8'h00;
    input_stride = 8'd1;
    weight_stride = 8'd1;
    length = 16'd4;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("wrap_iaddr", 32'(input_addr), 32'(exp_a[c]));
      @(negedge clk);
      start = 1'b0;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic dir_reset_mid();
    @(negedge clk);
    en = 1'b1;
    input_base = 8'h30;
    weight_base = 8'h60;
    input_stride = 8'd2;
    weight_stride = 8'd4;
    length = 16'd4;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        chk("rm_row2_iaddr", 32'(input_addr), 32'h34);
        chk("rm_row2_waddr", 32'(weight_addr), 32'h68);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero();
      end
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      chk("rm_no_done", 32'(done), 0);
      chk("rm_no_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    model_reset();
    #2;
    check_zero();
    @(negedge clk);
    rst_n = 1'b1;

    dir_basic(1'b0, 1'b0);
    dir_basic(1'b1, 1'b0);
    dir_basic(1'b0, 1'b1);
    dir_short(0);
    dir_short(1);
    dir_wrap();
    dir_reset_mid();

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        en = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 5) == 0);
        input_base = AW'($urandom);
        weight_base = AW'($urandom);
        input_stride = ($urandom_range(0, 1) == 0) ? AW'(1) : AW'($urandom);
        weight_stride = ($urandom_range(0, 1) == 0) ? AW'(1) : AW'($urandom);
        length = LW'($urandom_range(0, 5));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
